// File: rtl/jmb_window3x3.sv
// Streaming 3x3 neighbourhood extractor: two circular-buffer line delays feed a
// 3x3 register window; one border-qualified window is emitted per accepted pixel.
module jmb_window3x3 #(
  parameter int pixel_width  = 8,
  parameter int sl_width     = 512,
  parameter int frame_height = 512
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [pixel_width-1:0]   in_pixel,
  input  logic                     in_sof,
  output logic                     out_valid,
  output logic [9*pixel_width-1:0] out_window,
  output logic [15:0]              out_x,
  output logic [15:0]              out_y,
  output logic                     out_sof_err
);

  localparam int ptr_w = $clog2(sl_width);
  localparam logic [15:0] x_max = 16'(sl_width - 1);
  localparam logic [15:0] y_max = 16'(frame_height - 1);
  localparam logic [ptr_w-1:0] ptr_max = ptr_w'(sl_width - 1);

  typedef enum logic [1:0] {
    state_idle = 2'd0,
    state_fill = 2'd1,
    state_run  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [15:0] cnt_x, cnt_y;
  logic [15:0] cur_x, cur_y;
  logic        accept;
  logic        x_last, y_last;
  logic        win_emit;
  logic        sof_err_d;

  logic [ptr_w-1:0]       ptr;
  logic [pixel_width-1:0] line0_mem [sl_width];
  logic [pixel_width-1:0] line1_mem [sl_width];
  logic [pixel_width-1:0] line0_out, line1_out;

  logic [pixel_width-1:0] win_q [3][3];
  logic [pixel_width-1:0] win_d [3][3];
  logic [9*pixel_width-1:0] win_flat;

  // cnt_x/cnt_y hold the coordinate expected for the next accepted pixel
  always_comb begin
    accept    = in_valid && ((state_q != state_idle) || in_sof);
    cur_x     = in_sof ? 16'd0 : cnt_x;
    cur_y     = in_sof ? 16'd0 : cnt_y;
    x_last    = (cur_x == x_max);
    y_last    = (cur_y == y_max);
    win_emit  = accept && (cur_x >= 16'd2) && (cur_y >= 16'd2);
    line0_out = line0_mem[ptr];
    line1_out = line1_mem[ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= state_idle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    sof_err_d = 1'b0;
    if (accept) begin
      if (in_sof) begin
        state_d   = state_fill;
        sof_err_d = (state_q != state_idle) && ((cnt_x != 16'd0) || (cnt_y != 16'd0));
      end else begin
        case (state_q)
          state_fill: if (x_last && (cur_y == 16'd1)) state_d = state_run;
          state_run:  if (x_last && y_last)           state_d = state_idle;
          default:    state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_x <= 16'd0;
      cnt_y <= 16'd0;
      ptr   <= '0;
    end else if (accept) begin
      cnt_x <= x_last ? 16'd0 : cur_x + 16'd1;
      cnt_y <= x_last ? (y_last ? 16'd0 : cur_y + 16'd1) : cur_y;
      ptr   <= (ptr == ptr_max) ? '0 : ptr + ptr_w'(1);
    end
  end

  // Storage is never cleared; stale contents are masked by the x>=2/y>=2 rule.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      line0_mem[ptr] <= in_pixel;
      line1_mem[ptr] <= line0_out;
      win_q          <= win_d;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = line1_out;
    win_d[1][2] = line0_out;
    win_d[2][2] = in_pixel;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_flat[pixel_width*(3*r+c) +: pixel_width] = win_d[r][c];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_sof_err <= 1'b0;
      out_window  <= '0;
      out_x       <= 16'd0;
      out_y       <= 16'd0;
    end else begin
      out_valid   <= win_emit;
      out_sof_err <= sof_err_d;
      if (win_emit) begin
        out_window <= win_flat;
        out_x      <= cur_x - 16'd1;
        out_y      <= cur_y - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_jmb_window3x3.sv
// Directed bench for jmb_window3x3 on a 4x4 frame; expectations are queued per
// driven cycle and compared one cycle later.
module tb_jmb_window3x3;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic [PW-1:0]   in_pixel;
  logic            in_sof;
  logic            out_valid;
  logic [9*PW-1:0] out_window;
  logic [15:0]     out_x;
  logic [15:0]     out_y;
  logic            out_sof_err;

  always #5 clock = ~clock;

  jmb_window3x3 #(.pixel_width(PW), .sl_width(W), .frame_height(H)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_sof(in_sof), .out_valid(out_valid), .out_window(out_window),
    .out_x(out_x), .out_y(out_y), .out_sof_err(out_sof_err)
  );

  typedef struct {
    bit            v;
    bit            err;
    logic [9*PW-1:0] win;
    logic [15:0]   x;
    logic [15:0]   y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   errs = 0;
  bit   active = 0;

  function automatic logic [PW-1:0] pix(int tag, int x, int y);
    return PW'((tag << 6) | (y << 4) | x);
  endfunction

  task automatic chk(string tag, logic [9*PW-1:0] obs, logic [9*PW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    if (out_valid)   pulses++;
    if (out_sof_err) errs++;
    chk("out_valid", out_valid, got.v);
    if (got.v) begin
      chk("out_window", out_window, got.win);
      chk("out_x", out_x, got.x);
      chk("out_y", out_y, got.y);
    end
    chk("out_sof_err", out_sof_err, got.err);
  endtask

  task automatic send_px(int tag, int x, int y, bit sof);
    exp_t e;
    e = '{v: 1'b0, err: 1'b0, win: '0, x: '0, y: '0};
    in_valid = 1'b1;
    in_pixel = pix(tag, x, y);
    in_sof   = sof;
    if (sof) begin
      e.err  = active;
      active = 1'b1;
    end
    if (active && x >= 2 && y >= 2) begin
      e.v = 1'b1;
      e.x = 16'(x - 1);
      e.y = 16'(y - 1);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[PW*(3*r+c) +: PW] = pix(tag, x - 2 + c, y - 2 + r);
    end
    step(e);
    if (active && x == W-1 && y == H-1) active = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(int n);
    exp_t e;
    e = '{v: 1'b0, err: 1'b0, win: '0, x: '0, y: '0};
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_pixel = PW'($urandom);
      step(e);
    end
  endtask

  task automatic send_frame(int tag, bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        send_px(tag, x, y, (x == 0 && y == 0));
        if (gaps) idle(((y*W + x) % 2 == 0) ? 1 : int'($urandom_range(1, 5)));
      end
  endtask

  task automatic reset_cycle(int tag, int x, int y);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_sof   = 1'b0;
    in_pixel = pix(tag, x, y);
    @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_window", out_window, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_sof_err", out_sof_err, 0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    active   = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    @(posedge clock);
    reset_cycle(0, 0, 0);

    // continuous frame
    pulses = 0;
    send_frame(0, 1'b0);
    chk("frame0_pulses", pulses, 4);
    chk("frame0_idle", dut.state_q, 0);

    // frame with input gaps
    pulses = 0;
    send_frame(1, 1'b1);
    chk("gap_pulses", pulses, 4);

    // pixels without sof are discarded while idle
    pulses = 0;
    for (int i = 0; i < 10; i++) send_px(3, i % W, i / W, 1'b0);
    chk("nosof_pulses", pulses, 0);
    send_frame(2, 1'b0);
    chk("after_nosof_pulses", pulses, 4);

    // sof where (1,2) was expected restarts the frame
    pulses = 0;
    errs   = 0;
    for (int i = 0; i < 2*W + 1; i++) send_px(1, i % W, i / W, (i == 0));
    send_frame(2, 1'b0);
    chk("midsof_errs", errs, 1);
    chk("midsof_pulses", pulses, 4);

    // reset at (3,2) aborts the frame
    for (int i = 0; i < 2*W + 3; i++) send_px(3, i % W, i / W, (i == 0));
    reset_cycle(3, 3, 2);
    pulses = 0;
    send_frame(0, 1'b0);
    chk("post_reset_pulses", pulses, 4);

    // back-to-back frames
    pulses = 0;
    errs   = 0;
    send_frame(1, 1'b0);
    send_frame(2, 1'b0);
    chk("b2b_pulses", pulses, 8);
    chk("b2b_errs", errs, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
